// File: rtl/mod_99_rx_smd_decode.sv
// Receive-side byte staging FIFO for the MAC Merge path: tags each RS byte by
// its frame position and pre-decodes SMD / fragment-count codes at the FIFO head.
module mod_99_rx_smd_decode #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_begin,
  input  logic [7:0] rxd,
  input  logic       rx_dv,
  input  logic       rx_er,
  input  logic       rx_byte_strobe,
  input  logic       p_rx_byte_sent,
  output logic       r_rx_dv,
  output logic [7:0] r_rx_data,
  output logic       r_byte_ready,
  output logic       pream,
  output logic       s,
  output logic       c,
  output logic       e,
  output logic       v,
  output logic       r,
  output logic       err,
  output logic [1:0] c_frame_cnt,
  output logic [1:0] rx_frame_cnt,
  output logic [2:0] rx_frag_cnt,
  output logic       rx_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] KIND_PRE  = 2'd0;
  localparam logic [1:0] KIND_SMD  = 2'd1;
  localparam logic [1:0] KIND_FRAG = 2'd2;
  localparam logic [1:0] KIND_DATA = 2'd3;
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_FRAG, ST_DATA} in_state_e;

  // {hit, index} for the S set, which is also the fragment-count code set
  function automatic logic [2:0] s_code(input logic [7:0] d);
    case (d)
      8'hE6:   s_code = 3'b100;
      8'h4C:   s_code = 3'b101;
      8'h7F:   s_code = 3'b110;
      8'hB3:   s_code = 3'b111;
      default: s_code = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] c_code(input logic [7:0] d);
    case (d)
      8'h61:   c_code = 3'b100;
      8'h52:   c_code = 3'b101;
      8'h9E:   c_code = 3'b110;
      8'h2A:   c_code = 3'b111;
      default: c_code = 3'b000;
    endcase
  endfunction

  in_state_e   state_r, state_nxt_s;
  logic [AW:0] wptr_r, rptr_r;
  logic [11:0] mem_r [DEPTH];
  logic        eof_pend_r;
  logic [11:0] head_s, wdata_s;
  logic        empty_s, full_s, head_eof_s, head_byte_s, pop_s, space_s;
  logic        push_byte_s, eof_req_s, start_s, wr_eof_s, wr_byte_s, drop_s;
  logic [1:0]  push_kind_s, head_kind_s;
  logic [7:0]  head_data_s;
  logic        head_er_s;
  logic [2:0]  in_c_s, head_sc_s, head_cc_s;

  assign empty_s     = (wptr_r == rptr_r);
  assign full_s      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign head_s      = mem_r[rptr_r[AW-1:0]];
  assign head_data_s = head_s[11:4];
  assign head_er_s   = head_s[3];
  assign head_kind_s = head_s[2:1];
  assign head_eof_s  = head_s[0];
  assign head_byte_s = !empty_s && !head_eof_s;
  assign head_sc_s   = s_code(head_data_s);
  assign head_cc_s   = c_code(head_data_s);
  assign in_c_s      = c_code(rxd);
  // an eof head leaves on its own after one cycle so r_rx_dv can drop
  assign pop_s       = !empty_s && (head_eof_s || p_rx_byte_sent);
  assign space_s     = !full_s || pop_s;

  // Input FSM: classify each strobed byte and request an eof when rx_dv drops
  always_comb begin
    state_nxt_s = state_r;
    push_byte_s = 1'b0;
    push_kind_s = KIND_DATA;
    eof_req_s   = 1'b0;
    start_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_PRE: begin
        if ((state_r != ST_IDLE) && !rx_dv) begin
          eof_req_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (rx_dv && rx_byte_strobe) begin
          start_s     = (state_r == ST_IDLE);
          push_byte_s = 1'b1;
          if (rxd == 8'h55) begin
            push_kind_s = KIND_PRE;
            state_nxt_s = ST_PRE;
          end else begin
            push_kind_s = KIND_SMD;
            state_nxt_s = in_c_s[2] ? ST_FRAG : ST_DATA;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_FRAG: begin
        if (!rx_dv) begin
          eof_req_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (rx_byte_strobe) begin
          push_byte_s = 1'b1;
          push_kind_s = KIND_FRAG;
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_FRAG;
        end
      end
      ST_DATA: begin
        if (!rx_dv) begin
          eof_req_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (rx_byte_strobe) begin
          push_byte_s = 1'b1;
          push_kind_s = KIND_DATA;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Write-port arbitration: a pending or fresh eof owns the slot, bytes yield
  always_comb begin
    wr_eof_s  = 1'b0;
    wr_byte_s = 1'b0;
    drop_s    = 1'b0;
    wdata_s   = 12'h000;
    if (eof_pend_r || eof_req_s) begin
      wr_eof_s = space_s;
      wdata_s  = 12'h001;
      drop_s   = push_byte_s;
    end else if (push_byte_s) begin
      wr_byte_s = space_s;
      drop_s    = !space_s;
      wdata_s   = {rxd, rx_er, push_kind_s, 1'b0};
    end else begin
      wdata_s = 12'h000;
    end
  end

  // Head classification; everything reads 0 while the head is empty or eof
  always_comb begin
    r_byte_ready = head_byte_s;
    r_rx_data    = 8'h00;
    pream        = 1'b0;
    s            = 1'b0;
    c            = 1'b0;
    e            = 1'b0;
    v            = 1'b0;
    r            = 1'b0;
    err          = 1'b0;
    c_frame_cnt  = 2'd0;
    rx_frag_cnt  = 3'd0;
    if (head_byte_s) begin
      r_rx_data   = head_data_s;
      pream       = (head_kind_s == KIND_PRE) && (head_data_s == 8'h55);
      s           = (head_kind_s == KIND_SMD) && head_sc_s[2];
      c           = (head_kind_s == KIND_SMD) && head_cc_s[2];
      e           = (head_kind_s == KIND_SMD) && (head_data_s == 8'hD5);
      v           = (head_kind_s == KIND_SMD) && (head_data_s == 8'h07);
      r           = (head_kind_s == KIND_SMD) && (head_data_s == 8'h19);
      err         = head_er_s || ((head_kind_s == KIND_SMD) && !head_sc_s[2] && !head_cc_s[2]
                    && (head_data_s != 8'hD5) && (head_data_s != 8'h07) && (head_data_s != 8'h19));
      c_frame_cnt = c ? head_cc_s[1:0] : 2'd0;
      rx_frag_cnt = ((head_kind_s == KIND_FRAG) && head_sc_s[2]) ? {1'b0, head_sc_s[1:0]} : 3'b100;
    end else begin
      r_rx_data = 8'h00;
    end
  end

  // Control state, FIFO pointers and the registered status outputs
  always_ff @(posedge clk or posedge reset_begin) begin
    if (reset_begin) begin
      state_r      <= ST_IDLE;
      wptr_r       <= '0;
      rptr_r       <= '0;
      eof_pend_r   <= 1'b0;
      r_rx_dv      <= 1'b0;
      rx_frame_cnt <= 2'd0;
      rx_overflow  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      eof_pend_r <= (eof_pend_r || eof_req_s) && !space_s;
      if (wr_eof_s || wr_byte_s) wptr_r <= wptr_r + PTR_ONE;
      if (pop_s) rptr_r <= rptr_r + PTR_ONE;
      if (!empty_s) r_rx_dv <= !head_eof_s;
      if (pop_s && s) rx_frame_cnt <= head_sc_s[1:0];
      if (drop_s) rx_overflow <= 1'b1;
      else if (start_s) rx_overflow <= 1'b0;
    end
  end

  // FIFO storage; contents are only observed through a valid head
  always_ff @(posedge clk) begin
    if (wr_eof_s || wr_byte_s) mem_r[wptr_r[AW-1:0]] <= wdata_s;
  end

endmodule
